// File: rtl/proc_pkg.sv
// Shared definitions for the register-file processor front end.
// Instruction field layout, opcodes and issuer FSM states.
package proc_pkg;

  localparam int INSTR_W = 34;
  localparam int DATA_W  = 16;
  localparam int WAIT_W  = 8;

  localparam int OPC_MSB = 33;
  localparam int OPC_LSB = 31;
  localparam int RA1_MSB = 30;
  localparam int RA1_LSB = 26;
  localparam int RA2_MSB = 25;
  localparam int RA2_LSB = 21;
  localparam int WA_MSB  = 20;
  localparam int WA_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_WRITE = 3'b000;
  localparam opcode_t OP_READ  = 3'b001;
  localparam opcode_t OP_ADD   = 3'b010;
  localparam opcode_t OP_SUB   = 3'b011;
  localparam opcode_t OP_AND   = 3'b100;
  localparam opcode_t OP_OR    = 3'b101;
  localparam opcode_t OP_XOR   = 3'b110;
  localparam opcode_t OP_SHL   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  function automatic opcode_t opc_of(
    input logic [INSTR_W-1:0] ins
  );
    return ins[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO with occupancy count.
// Head entry is presented combinationally on data_o.
module instr_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 34,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // a pop frees the slot, so a push into a full FIFO is fine then
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_issuer.sv
// Issues buffered host instructions to the processor with the
// prepare/issue handshake and returns captured read data.
module instruction_issuer
  import proc_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 32,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [INSTR_W-1:0] instruct,
  output logic               instruct_sig,
  input  logic               output_sig,
  input  logic [DATA_W-1:0]  out1,
  input  logic [DATA_W-1:0]  out2,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_out1,
  output logic [DATA_W-1:0]  res_out2,
  output logic [2:0]         res_opcode,
  output logic               res_timeout,
  output logic               busy,
  output logic [CW-1:0]      fifo_count
);

  localparam logic [WAIT_W-1:0] TMO_CNT = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instruct_q, instruct_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                tmo_q, tmo_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_out1_q, res_out1_d;
  logic [DATA_W-1:0]   res_out2_q, res_out2_d;
  opcode_t             res_opc_q, res_opc_d;
  logic                res_tmo_q, res_tmo_d;

  logic                fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [INSTR_W-1:0]  fifo_head;

  assign fifo_pop  = (state_q == ST_IDLE) &&
                     !fifo_empty && !res_valid_q;
  assign in_ready  = !fifo_full || fifo_pop;
  assign fifo_push = in_valid && in_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (in_instr),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    instruct_d  = instruct_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    res_valid_d = res_valid_q;
    res_out1_d  = res_out1_q;
    res_out2_d  = res_out2_q;
    res_opc_d   = res_opc_q;
    res_tmo_d   = res_tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          instruct_d = fifo_head;
          wait_d     = '0;
          tmo_d      = 1'b0;
          state_d    = ST_PREP;
        end
      end
      ST_PREP: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
        if (output_sig) begin
          state_d = ST_CAPTURE;
        end else if (wait_d >= TMO_CNT) begin
          tmo_d   = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        res_out1_d  = out1;
        res_out2_d  = out2;
        res_opc_d   = opc_of(instruct_q);
        res_tmo_d   = tmo_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instruct_q  <= '0;
      wait_q      <= '0;
      tmo_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_out1_q  <= '0;
      res_out2_q  <= '0;
      res_opc_q   <= '0;
      res_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instruct_q  <= instruct_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_out1_q  <= res_out1_d;
      res_out2_q  <= res_out2_d;
      res_opc_q   <= res_opc_d;
      res_tmo_q   <= res_tmo_d;
    end
  end

  // decoded from state so reset drops it without a clock
  assign instruct_sig = (state_q == ST_ISSUE);
  assign instruct     = instruct_q;
  assign res_valid    = res_valid_q;
  assign res_out1     = res_out1_q;
  assign res_out2     = res_out2_q;
  assign res_opcode   = res_opc_q;
  assign res_timeout  = res_tmo_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed bench for instruction_issuer with a small processor
// model and a result scoreboard.
module tb_instruction_issuer;
  import proc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [33:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] instruct;
  logic        instruct_sig;
  logic        output_sig;
  logic [15:0] out1, out2;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_out1, res_out2;
  logic [2:0]  res_opcode;
  logic        res_timeout;
  logic        busy;
  logic [2:0]  fifo_count;

  instruction_issuer #(.DEPTH(4), .TIMEOUT(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_instr     (in_instr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instruct     (instruct),
    .instruct_sig (instruct_sig),
    .output_sig   (output_sig),
    .out1         (out1),
    .out2         (out2),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_out1     (res_out1),
    .res_out2     (res_out2),
    .res_opcode   (res_opcode),
    .res_timeout  (res_timeout),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] o1;
    logic [15:0] o2;
    logic [2:0]  opc;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic [2:0] op,
                                     input logic [4:0] a1,
                                     input logic [4:0] a2,
                                     input logic [4:0] wa,
                                     input logic [15:0] imm);
    return {op, a1, a2, wa, imm};
  endfunction

  // processor model: reads at issue start, writes for OP_WRITE,
  // raises output_sig 'lat' cycles after instruct_sig rises
  logic [15:0] rf [32];
  int lat = 3;
  int hi  = 0;

  initial begin
    output_sig = 1'b0;
    out1 = '0;
    out2 = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !instruct_sig) begin
        hi = 0;
        output_sig = 1'b0;
      end else begin
        hi++;
        if (hi == 1) begin
          out1 = rf[instruct[30:26]];
          out2 = rf[instruct[25:21]];
          if (instruct[33:31] == OP_WRITE)
            rf[instruct[20:16]] = instruct[15:0];
        end
        output_sig = (lat > 0) && (hi == lat);
      end
    end
  end

  // result consumed at the next edge: compare against scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("res_out1", res_out1, e.o1);
          chk("res_out2", res_out2, e.o2);
          chk("res_opcode", res_opcode, e.opc);
          chk("res_timeout", res_timeout, e.to);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [33:0] ins,
                      input logic [15:0] e1,
                      input logic [15:0] e2,
                      input logic to,
                      input bit track);
    bit ok = 0;
    in_instr = ins;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) ok = 1;
      tick(1);
    end
    in_valid = 1'b0;
    chk("push_accepted", 64'(ok), 1);
    if (ok && track) sb.push_back('{e1, e2, ins[33:31], to});
  endtask

  task automatic drain();
    bit done = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      tick(1);
      done = (sb.size() == 0) && !busy && !res_valid;
    end
    chk("drain", 64'(done), 1);
    res_ready = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      seen = res_valid;
    end
    chk("wait_res_valid", 64'(seen), 1);
  endtask

  task automatic rst_checks();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_instruct", instruct, 0);
    chk("rst_instruct_sig", instruct_sig, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_out1", res_out1, 0);
    chk("rst_res_out2", res_out2, 0);
    chk("rst_res_opcode", res_opcode, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
  endtask

  initial begin
    logic [33:0] a_ins;
    bit          seen;
    rst_n     = 1'b0;
    in_instr  = '0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    #1;
    rst_checks();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // single write with full handshake timing
    lat = 3;
    push(34'h0_0001_ABCD, 16'h0, 16'h0, 1'b0, 1);
    chk("w_count_after_push", fifo_count, 1);
    tick(1);
    chk("w_prep_sig", instruct_sig, 0);
    chk("w_prep_instr", instruct, 34'h0_0001_ABCD);
    chk("w_prep_count", fifo_count, 0);
    chk("w_prep_busy", busy, 1);
    tick(1);
    chk("w_issue_sig", instruct_sig, 1);
    tick(2);
    chk("w_issue_novalid", res_valid, 0);
    tick(1);
    chk("w_capture_sig", instruct_sig, 0);
    chk("w_capture_novalid", res_valid, 0);
    tick(1);
    chk("w_res_valid", res_valid, 1);
    chk("w_res_opcode", res_opcode, OP_WRITE);
    chk("w_res_timeout", res_timeout, 0);
    drain();
    chk("w_valid_cleared", res_valid, 0);

    // back-to-back write then read
    res_ready = 1'b1;
    push(mk(OP_WRITE, 5'd0, 5'd0, 5'd2, 16'h1234),
         16'h0, 16'h0, 1'b0, 1);
    push(mk(OP_READ, 5'd1, 5'd2, 5'd0, 16'h0),
         16'hABCD, 16'h1234, 1'b0, 1);
    drain();

    // timeout, then backpressure with one instruction queued
    lat = -1;
    a_ins = mk(OP_READ, 5'd1, 5'd2, 5'd0, 16'h0);
    push(a_ins, 16'hABCD, 16'h1234, 1'b1, 1);
    push(mk(OP_SHL, 5'd2, 5'd1, 5'd9, 16'h3),
         16'h1234, 16'hABCD, 1'b0, 1);
    tick(1);
    chk("t_issue_sig", instruct_sig, 1);
    chk("t_issue_instr", instruct, a_ins);
    tick(32);
    chk("t_valid_early", res_valid, 0);
    tick(1);
    chk("t_valid", res_valid, 1);
    chk("t_timeout_flag", res_timeout, 1);
    lat = 3;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_res_out1", res_out1, 16'hABCD);
      chk("bp_res_out2", res_out2, 16'h1234);
      chk("bp_timeout", res_timeout, 1);
      chk("bp_count", fifo_count, 1);
      chk("bp_instr", instruct, a_ins);
      chk("bp_sig", instruct_sig, 0);
    end
    drain();

    // FIFO full while a result is held
    push(mk(OP_WRITE, 5'd0, 5'd0, 5'd3, 16'h5555),
         16'h0, 16'h0, 1'b0, 1);
    wait_valid();
    push(mk(OP_ADD, 5'd3, 5'd1, 5'd4, 16'h0),
         16'h5555, 16'hABCD, 1'b0, 1);
    push(mk(OP_SUB, 5'd1, 5'd3, 5'd4, 16'h0),
         16'hABCD, 16'h5555, 1'b0, 1);
    push(mk(OP_AND, 5'd2, 5'd3, 5'd4, 16'h0),
         16'h1234, 16'h5555, 1'b0, 1);
    push(mk(OP_OR, 5'd3, 5'd2, 5'd4, 16'h0),
         16'h5555, 16'h1234, 1'b0, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", fifo_count, 4);
    in_instr = mk(OP_XOR, 5'd1, 5'd1, 5'd4, 16'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("full_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("full_count_kept", fifo_count, 4);
    drain();

    // asynchronous reset in the middle of ISSUE
    lat = -1;
    push(mk(OP_READ, 5'd1, 5'd0, 5'd0, 16'h0),
         16'h0, 16'h0, 1'b0, 0);
    push(mk(OP_READ, 5'd2, 5'd0, 5'd0, 16'h0),
         16'h0, 16'h0, 1'b0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      seen = instruct_sig;
      if (!seen) tick(1);
    end
    chk("mr_reach_issue", 64'(seen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    rst_checks();
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("mr_no_result", res_valid, 0);
    chk("mr_idle", busy, 0);
    chk("mr_count", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instruction_issuer.md
# instruction_issuer

Front-end sequencer that drives the 34-bit instruction port of the register-file processor. It buffers instructions from a host in a small FIFO and issues them one at a time using the processor's prepare/issue handshake. It waits for the completion flag, then captures the two read buses into a result register presented to the host with a valid/ready handshake. It sits between the testbench/host and the processor, and is the initiator side of that processor's instruction protocol.

## Interface
- DEPTH, 4: instruction FIFO entries (power of two, ≥2)
- TIMEOUT, 32: cycles to wait for completion before abort (≤255)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_instr  in  34  host instruction: [33:31] opcode, [30:26] read addr 1, [25:21] read addr 2, [20:16] write addr, [15:0] immediate/write data
- in_valid  in  1  host offers in_instr
- in_ready  out  1  FIFO not full
- instruct  out  34  instruction to processor
- instruct_sig  out  1  0 = prepare, 1 = instruction valid/held
- output_sig  in  1  processor completion flag, sampled on rising clk
- out1, out2  in  16  processor read buses
- res_valid  out  1  result register holds an unread result
- res_ready  in  1  host accepts result
- res_out1, res_out2  out  16  captured read data
- res_opcode  out  3  opcode of the completed instruction
- res_timeout  out  1  result was produced by timeout abort, not completion
- busy  out  1  FSM not in IDLE or FIFO non-empty
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO push occurs when in_valid && in_ready. Pop occurs on the IDLE→PREP transition. Push and pop in the same cycle leave the count unchanged, and this is legal even when the FIFO is full. Pointers wrap modulo DEPTH.
- FSM states are IDLE, PREP, ISSUE, CAPTURE, HOLD.
- IDLE: instruct_sig=0. If the FIFO is non-empty and res_valid=0, pop the head into the instruct register and go to PREP.
- PREP: instruct_sig=0 for exactly one cycle. The processor uses this cycle to arm. Then go to ISSUE.
- ISSUE: instruct_sig=1 and instruct held stable. The wait counter increments each cycle.
  - If output_sig=1, go to CAPTURE.
  - Else if the counter reaches TIMEOUT, set the timeout flag and go to CAPTURE.
- CAPTURE: latch out1, out2 and the opcode into the res_* registers, set res_valid, drive instruct_sig=0, then go to HOLD.
- HOLD: wait until res_valid && res_ready, which clears res_valid, then return to IDLE. res_* values are frozen while res_valid=1.
- Opcodes with no read (000) still capture out1/out2 as presented. The host ignores them.
- Arithmetic is limited to the FIFO count and an 8-bit wait counter. The wait counter saturates and clears on entry to PREP.

## Timing
- Reset values: in_ready=1, instruct=0, instruct_sig=0, res_valid=0, res_out1=res_out2=0, res_opcode=0, res_timeout=0, busy=0, fifo_count=0. FIFO is emptied and FSM goes to IDLE.
- Reset asserted mid-operation aborts immediately. No result is produced and instruct_sig drops to 0 asynchronously.
- A push at edge N is visible as fifo_count+1 after edge N. With the FSM in IDLE and res_valid=0, it is popped at edge N+1.
- Latency from a pop to instruct_sig=1 is 1 cycle (PREP).
- output_sig seen high at edge M gives res_valid=1 after edge M+1.
- Timeout: if output_sig is not seen, res_valid rises TIMEOUT+1 cycles after the ISSUE entry, with res_timeout=1.
- output_sig high outside ISSUE is ignored.
- res_ready held high gives back-to-back results. The IDLE→PREP pop occurs the cycle after the result is consumed.

## Structure
- Shared package proc_pkg holds:
  - instruction field offsets and widths (OPC_MSB=33, OPC_LSB=31, etc.);
  - opcode constants OP_WRITE=000 … OP_SHL=111;
  - the FSM state enum.
- One sub-module, instr_fifo: synchronous FIFO with parameters DEPTH and WIDTH=34, count output, and async active-low reset.

## Test plan
- Reset mid-ISSUE: reset asserted while instruct_sig=1 → all outputs return to their reset values with no clock edge required, and fifo_count=0.
- Single write: push 34'h0_0001_ABCD (opcode 000, write addr 1, data 0xABCD). The processor model asserts output_sig 3 cycles after instruct_sig rises.
  - Response: instruct_sig goes 0 for one cycle, then 1.
  - Response: res_valid=1 with res_opcode=0 and res_timeout=0.
- FIFO full: push 5 instructions with res_ready=0 and the FSM stalled → in_ready=0 after the 4th push is held.
- Back-to-back issue: push write then read (opcode 001, addr 1) with the model returning out1=16'hABCD → second result has res_out1=16'hABCD and res_opcode=001.
- Timeout: the model never asserts output_sig → res_valid rises 33 cycles after ISSUE entry with res_timeout=1, and the next queued instruction issues afterwards.
- Result backpressure: hold res_ready=0 for 10 cycles while 2 instructions are queued → res_* stays stable, no second PREP occurs, and fifo_count stays at 1 until the result is accepted.
